// File: rtl/position_sampler.sv
// Two-wheel encoder tick sampler: counts synchronized encoder rising edges over
// fixed windows of PERIOD clocks and presents each window's counts with a valid/ack handshake.
module position_sampler #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       enc_l,
    input  logic       enc_r,
    input  logic       ack,
    output logic [5:0] cnt_l,
    output logic [5:0] cnt_r,
    output logic       sat_l,
    output logic       sat_r,
    output logic       valid,
    output logic       overrun
);

    localparam int unsigned   CW   = (PERIOD > 32'd1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 32'd1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    function automatic logic [5:0] sat_inc(input logic [5:0] acc, input logic tick);
        if (tick && (acc != 6'd63)) begin
            return acc + 6'd1;
        end else begin
            return acc;
        end
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    sync_l_r;
    logic [1:0]    sync_r_r;
    logic          prev_l_r;
    logic          prev_r_r;
    logic [1:0]    warm_r;
    logic          armed_l_r;
    logic          armed_r_r;
    logic [5:0]    acc_l_r;
    logic [5:0]    acc_r_r;
    logic          flag_l_r;
    logic          flag_r_r;
    logic [CW-1:0] win_cnt_r;

    logic          tick_l_s;
    logic          tick_r_s;
    logic [5:0]    acc_l_s;
    logic [5:0]    acc_r_s;
    logic          hit_l_s;
    logic          hit_r_s;
    logic          win_end_s;
    logic          keep_s;

    // Synchronizers and edge history. A side is only armed once its stage-2 value
    // has been seen low from a real input sample, so a level already high at reset
    // release never looks like a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l_r  <= 2'b00;
            sync_r_r  <= 2'b00;
            prev_l_r  <= 1'b0;
            prev_r_r  <= 1'b0;
            warm_r    <= 2'b00;
            armed_l_r <= 1'b0;
            armed_r_r <= 1'b0;
        end else begin
            sync_l_r  <= {sync_l_r[0], enc_l};
            sync_r_r  <= {sync_r_r[0], enc_r};
            prev_l_r  <= sync_l_r[1];
            prev_r_r  <= sync_r_r[1];
            warm_r    <= {warm_r[0], 1'b1};
            armed_l_r <= armed_l_r | (warm_r[1] & ~sync_l_r[1]);
            armed_r_r <= armed_r_r | (warm_r[1] & ~sync_r_r[1]);
        end
    end

    // Tick detection, saturating next-accumulator values and window-end decode.
    always_comb begin
        tick_l_s  = sync_l_r[1] & ~prev_l_r & armed_l_r;
        tick_r_s  = sync_r_r[1] & ~prev_r_r & armed_r_r;
        acc_l_s   = sat_inc(acc_l_r, tick_l_s);
        acc_r_s   = sat_inc(acc_r_r, tick_r_s);
        hit_l_s   = flag_l_r | (tick_l_s & (acc_l_r == 6'd63));
        hit_r_s   = flag_r_r | (tick_r_s & (acc_r_r == 6'd63));
        win_end_s = (state_r == COUNT) && (win_cnt_r == LAST);
        keep_s    = (state_r == COUNT) && (state_s == COUNT);
    end

    // Next-state logic: en alone selects between idle and counting.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (en) state_s = COUNT;
                else    state_s = IDLE;
            end
            COUNT: begin
                if (en) state_s = COUNT;
                else    state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Window counter and accumulators; any exit from counting discards the partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r <= {CW{1'b0}};
            acc_l_r   <= 6'd0;
            acc_r_r   <= 6'd0;
            flag_l_r  <= 1'b0;
            flag_r_r  <= 1'b0;
        end else if (keep_s && !win_end_s) begin
            win_cnt_r <= win_cnt_r + CW'(1);
            acc_l_r   <= acc_l_s;
            acc_r_r   <= acc_r_s;
            flag_l_r  <= hit_l_s;
            flag_r_r  <= hit_r_s;
        end else begin
            win_cnt_r <= {CW{1'b0}};
            acc_l_r   <= 6'd0;
            acc_r_r   <= 6'd0;
            flag_l_r  <= 1'b0;
            flag_r_r  <= 1'b0;
        end
    end

    // Presented sample and handshake; a new sample wins over a same-edge ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_l   <= 6'd0;
            cnt_r   <= 6'd0;
            sat_l   <= 1'b0;
            sat_r   <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (win_end_s) begin
            cnt_l   <= acc_l_s;
            cnt_r   <= acc_r_s;
            sat_l   <= hit_l_s;
            sat_r   <= hit_r_s;
            valid   <= 1'b1;
            overrun <= valid & ~ack;
        end else if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= valid;
            overrun <= overrun;
        end
    end

endmodule

// File: tb/tb_position_sampler.sv
// Directed bench for position_sampler: a PERIOD=16 instance for timing/handshake
// cases and a PERIOD=256 instance for saturation.
module tb_position_sampler;

    logic       clk;
    logic       rst;
    logic       en, enc_l, enc_r, ack;
    logic [5:0] cnt_l, cnt_r;
    logic       sat_l, sat_r, valid, overrun;
    logic       en_b, enc_l_b, enc_r_b, ack_b;
    logic [5:0] cnt_l_b, cnt_r_b;
    logic       sat_l_b, sat_r_b, valid_b, overrun_b;

    int n_checks = 0;
    int n_pass   = 0;

    position_sampler #(.PERIOD(16)) dut (
        .clk(clk), .rst(rst), .en(en), .enc_l(enc_l), .enc_r(enc_r), .ack(ack),
        .cnt_l(cnt_l), .cnt_r(cnt_r), .sat_l(sat_l), .sat_r(sat_r),
        .valid(valid), .overrun(overrun)
    );

    position_sampler #(.PERIOD(256)) dut_big (
        .clk(clk), .rst(rst), .en(en_b), .enc_l(enc_l_b), .enc_r(enc_r_b), .ack(ack_b),
        .cnt_l(cnt_l_b), .cnt_r(cnt_r_b), .sat_l(sat_l_b), .sat_r(sat_r_b),
        .valid(valid_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle-high, one-cycle-low pulses starting at the current negedge.
    task automatic pulses(input int nl, input int nr, input bit big);
        int m;
        m = (nl > nr) ? nl : nr;
        for (int i = 0; i < m; i++) begin
            if (big) begin
                enc_l_b = (i < nl);
                enc_r_b = (i < nr);
            end else begin
                enc_l = (i < nl);
                enc_r = (i < nr);
            end
            step(1);
            enc_l = 1'b0; enc_r = 1'b0; enc_l_b = 1'b0; enc_r_b = 1'b0;
            step(1);
        end
    endtask

    task automatic check_sample(input string tag, input int cl, input int cr,
                                input int v, input int ov);
        check({tag, "_cnt_l"},   8'(cnt_l),   8'(cl));
        check({tag, "_cnt_r"},   8'(cnt_r),   8'(cr));
        check({tag, "_valid"},   8'(valid),   8'(v));
        check({tag, "_overrun"}, 8'(overrun), 8'(ov));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; enc_l = 1'b0; enc_r = 1'b0; ack = 1'b0;
        en_b = 1'b0; enc_l_b = 1'b0; enc_r_b = 1'b0; ack_b = 1'b0;
        step(2);
        rst = 1'b0;
        check_sample("reset", 0, 0, 0, 0);
        check("reset_sat_l", 8'(sat_l), 8'd0);
        check("reset_big_valid", 8'(valid_b), 8'd0);
        step(1);

        // Basic window: 5 left, 3 right ticks; en set at N0, sample visible at N17.
        en = 1'b1;
        step(1);
        pulses(5, 3, 1'b0);
        step(5);
        check("basic_not_early", 8'(valid), 8'd0);
        step(1);
        check_sample("basic", 5, 3, 1, 0);
        check("basic_sat_l", 8'(sat_l), 8'd0);
        check("basic_sat_r", 8'(sat_r), 8'd0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("basic_ack", 8'(valid), 8'd0);

        // Overrun: two window ends without ack, then ack, then ack on a window end.
        pulses(2, 0, 1'b0);
        step(11);
        check_sample("win2", 2, 0, 1, 0);
        pulses(0, 1, 1'b0);
        step(14);
        check_sample("win3_overrun", 0, 1, 1, 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ovr_ack_valid", 8'(valid), 8'd0);
        check("ovr_ack_overrun", 8'(overrun), 8'd0);
        step(15);
        check_sample("win4", 0, 0, 1, 0);
        step(15);
        ack = 1'b1;
        step(1);
        check_sample("ack_at_end", 0, 0, 1, 0);
        step(1);
        ack = 1'b0;

        // Boundary: left tick on the window-end cycle, right tick on the first new cycle.
        step(12);
        enc_l = 1'b1;
        step(1);
        enc_l = 1'b0; enc_r = 1'b1;
        step(1);
        enc_l = 1'b1; enc_r = 1'b0;
        step(1);
        enc_l = 1'b0;
        check_sample("boundary_close", 1, 0, 1, 0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(14);
        enc_l = 1'b1;
        step(1);
        enc_l = 1'b0;
        check_sample("boundary_next", 1, 1, 1, 0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;

        // Partial window: 4 ticks in, en dropped at counter 8, ticks while idle, re-enable.
        pulses(3, 0, 1'b0);
        step(1);
        en = 1'b0;
        pulses(2, 0, 1'b0);
        step(2);
        check("partial_no_sample", 8'(valid), 8'd0);
        en = 1'b1;
        step(1);
        pulses(3, 2, 1'b0);
        step(9);
        check("reenable_not_early", 8'(valid), 8'd0);
        step(1);
        check_sample("reenable", 3, 2, 1, 0);

        // Asynchronous reset between edges with valid=1, enc_r held high through release.
        enc_r = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_sample("async_rst", 0, 0, 0, 0);
        check("async_rst_sat_l", 8'(sat_l), 8'd0);
        check("async_rst_sat_r", 8'(sat_r), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step(16);
        check("post_rst_not_early", 8'(valid), 8'd0);
        step(1);
        check_sample("post_rst_no_tick", 0, 0, 1, 0);
        enc_r = 1'b0;

        // Saturation on the PERIOD=256 instance.
        en_b = 1'b1;
        step(1);
        pulses(70, 0, 1'b1);
        step(115);
        check("sat_not_early", 8'(valid_b), 8'd0);
        step(1);
        check("sat_cnt_l", 8'(cnt_l_b), 8'd63);
        check("sat_sat_l", 8'(sat_l_b), 8'd1);
        check("sat_cnt_r", 8'(cnt_r_b), 8'd0);
        check("sat_sat_r", 8'(sat_r_b), 8'd0);
        check("sat_valid", 8'(valid_b), 8'd1);
        ack_b = 1'b1;
        step(1);
        ack_b = 1'b0;
        pulses(2, 0, 1'b1);
        step(251);
        check("unsat_cnt_l", 8'(cnt_l_b), 8'd2);
        check("unsat_sat_l", 8'(sat_l_b), 8'd0);
        check("unsat_valid", 8'(valid_b), 8'd1);
        check("unsat_overrun", 8'(overrun_b), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/position_sampler.md
POSITION_SAMPLER -- requirements
Module: position_sampler

Interface
REQ-001 Parameter PERIOD, default 50000, sample-window length in clk cycles (legal 4..2^20).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  sampling enable; high = windows run, low = idle.
REQ-005 enc_l  input  1  left-wheel encoder pulse, asynchronous to clk.
REQ-006 enc_r  input  1  right-wheel encoder pulse, asynchronous to clk.
REQ-007 ack  input  1  consumer acknowledge for the presented sample.
REQ-008 cnt_l  output  6  left tick count of last completed window.
REQ-009 cnt_r  output  6  right tick count of last completed window.
REQ-010 sat_l, sat_r  output  1 each  window count saturated at 63.
REQ-011 valid  output  1  sample presented, awaiting ack.
REQ-012 overrun  output  1  presented sample replaced an unacknowledged one.

Function
REQ-013 Each encoder input SHALL pass through a 2-flop synchronizer; a tick SHALL be flagged when sync stage 2 is 1 and its previous-cycle value is 0.
REQ-014 A tick SHALL increment its 6-bit accumulator on the same clk edge it is flagged; an input rise is reflected in the accumulator at most 3 clk edges later.
REQ-015 Accumulators SHALL saturate at 63; a tick arriving at 63 SHALL set that side's window-saturation flag and leave the accumulator at 63.
REQ-016 FSM states: IDLE, COUNT. IDLE -> COUNT when en=1; COUNT -> IDLE when en=0; no other transitions.
REQ-017 In IDLE, accumulators, saturation flags and window counter SHALL be held at 0; synchronizers keep running; cnt_*, sat_*, valid, overrun hold their values.
REQ-018 In COUNT, window counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-019 Window end = COUNT and window counter = PERIOD-1; on that edge cnt_*/sat_* SHALL load the accumulator values including any tick flagged that same cycle, accumulators and flags SHALL clear to 0, and valid SHALL be 1 the next cycle.
REQ-020 A tick flagged in the first window cycle after a window end SHALL count in the new window; no tick is lost or double-counted across the boundary.
REQ-021 valid SHALL stay 1 until ack is sampled 1, then go 0 on that edge; ack while valid=0 SHALL be ignored.
REQ-022 Window end with valid=1 and ack=0: new sample SHALL overwrite outputs, valid stays 1, overrun SHALL be set to 1.
REQ-023 Window end with valid=1 and ack=1 on the same edge: new sample loaded, valid stays 1, overrun SHALL be 0.
REQ-024 overrun SHALL clear when ack is accepted; it is never set without valid=1.
REQ-025 en falling mid-window SHALL discard the partial window without producing a sample; en rising SHALL start a window at counter value 0.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, synchronizers, accumulators, window counter, cnt_l, cnt_r, sat_l, sat_r, valid and overrun to 0, independent of clk.
REQ-027 After rst deasserts, first window SHALL start on the first clk edge with en=1; an encoder input already high at reset release SHALL NOT generate a tick.

Verification (PERIOD=16)
REQ-028 en=1, 5 clean enc_l pulses, 3 enc_r pulses within window -> at window end cnt_l=5, cnt_r=3, sat_*=0, valid=1; ack -> valid=0 next edge.
REQ-029 70 enc_l pulses across windows of PERIOD=256 -> cnt_l=63, sat_l=1; next window with 2 pulses -> cnt_l=2, sat_l=0.
REQ-030 No ack across two window ends -> second sample presented, overrun=1; ack -> valid=0, overrun=0; ack coincident with window end -> valid=1, overrun=0.
REQ-031 enc_l rise timed so tick flags on window-end cycle, another on the next cycle -> closing sample includes first, next sample includes second.
REQ-032 en dropped at counter=8 with 4 ticks accumulated, re-raised -> no sample for partial window; next sample reflects only post-re-enable ticks, exactly 16 cycles after re-enable.
REQ-033 rst pulsed asynchronously between clk edges mid-window with valid=1 -> all outputs 0 before next clk edge; enc_r held high through release -> no tick.
